// File: rtl/pipe_pkg.sv
// Shared definitions for the destination-register pipeline: default register-number
// width and the EX operand forwarding select encoding.
package pipe_pkg;

  localparam int REG_W_DEF = 4;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/dst_stage_reg.sv
// One pipeline stage of destination register number plus control flags.
// Async active-high reset clears everything; hold keeps the current contents.
module dst_stage_reg #(
  parameter int REG_W  = 4,
  parameter int FLAG_W = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              hold_i,
  input  logic [REG_W-1:0]  dst_i,
  input  logic [FLAG_W-1:0] flags_i,
  output logic [REG_W-1:0]  dst_o,
  output logic [FLAG_W-1:0] flags_o
);

  logic [REG_W-1:0]  dst_q,   dst_d;
  logic [FLAG_W-1:0] flags_q, flags_d;

  assign dst_d   = hold_i ? dst_q   : dst_i;
  assign flags_d = hold_i ? flags_q : flags_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dst_q   <= '0;
      flags_q <= '0;
    end else begin
      dst_q   <= dst_d;
      flags_q <= flags_d;
    end
  end

  assign dst_o   = dst_q;
  assign flags_o = flags_q;

endmodule

// File: rtl/dst_reg_pipe.sv
// Carries the EX write destination through EX/MEM and MEM/WB, and derives the
// EX operand forwarding selects and the load-use stall request from it.
module dst_reg_pipe
  import pipe_pkg::*;
#(
  parameter int REG_W        = REG_W_DEF,
  parameter bit R0_HARDWIRED = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] ex_dst,
  input  logic             ex_valid,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             hold,
  output logic [REG_W-1:0] mem_dst,
  output logic             mem_regwrite,
  output logic             mem_memread,
  output logic [REG_W-1:0] wb_dst,
  output logic             wb_regwrite,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             load_use_stall
);

  logic       dst_is_r0;
  logic       we;
  logic       ld;
  logic [1:0] mem_flags_d;
  logic [1:0] mem_flags;
  logic [0:0] wb_flags;

  assign dst_is_r0 = (ex_dst == '0);
  // Clearing the write enable for r0 here is what keeps r0 out of forwarding.
  assign we = ex_valid & ex_regwrite & ~(R0_HARDWIRED & dst_is_r0);
  assign ld = ex_valid & ex_memread;

  assign mem_flags_d = {ld, we};

  dst_stage_reg #(
    .REG_W  (REG_W),
    .FLAG_W (2)
  ) u_ex_mem (
    .clk_i   (clk),
    .rst_i   (rst),
    .hold_i  (hold),
    .dst_i   (ex_dst),
    .flags_i (mem_flags_d),
    .dst_o   (mem_dst),
    .flags_o (mem_flags)
  );

  assign mem_regwrite = mem_flags[0];
  assign mem_memread  = mem_flags[1];

  dst_stage_reg #(
    .REG_W  (REG_W),
    .FLAG_W (1)
  ) u_mem_wb (
    .clk_i   (clk),
    .rst_i   (rst),
    .hold_i  (hold),
    .dst_i   (mem_dst),
    .flags_i (mem_regwrite),
    .dst_o   (wb_dst),
    .flags_o (wb_flags)
  );

  assign wb_regwrite = wb_flags[0];

  // The younger result in MEM takes priority over the older one in WB.
  function automatic logic [1:0] fwd_sel(
    input logic             m_we,
    input logic [REG_W-1:0] m_dst,
    input logic             w_we,
    input logic [REG_W-1:0] w_dst,
    input logic [REG_W-1:0] src
  );
    if (m_we && (m_dst == src))      return FWD_MEM;
    else if (w_we && (w_dst == src)) return FWD_WB;
    else                             return FWD_REG;
  endfunction

  assign fwd_a = fwd_sel(mem_regwrite, mem_dst, wb_regwrite, wb_dst, ex_rs);
  assign fwd_b = fwd_sel(mem_regwrite, mem_dst, wb_regwrite, wb_dst, ex_rt);

  assign load_use_stall = ld & (~dst_is_r0 | ~R0_HARDWIRED) &
                          ((ex_dst == id_rs) | (ex_dst == id_rt));

endmodule

// File: tb/tb_dst_reg_pipe.sv
// Self-checking bench for dst_reg_pipe: directed table, hold/reset sequences,
// and randomized cycles against a behavioural pipeline model.
module tb_dst_reg_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ex_dst, ex_rs, ex_rt, id_rs, id_rt;
  logic       ex_valid, ex_regwrite, ex_memread, hold;
  logic [3:0] mem_dst, wb_dst;
  logic       mem_regwrite, mem_memread, wb_regwrite;
  logic [1:0] fwd_a, fwd_b;
  logic       load_use_stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dst_reg_pipe dut (
    .clk            (clk),
    .rst            (rst),
    .ex_dst         (ex_dst),
    .ex_valid       (ex_valid),
    .ex_regwrite    (ex_regwrite),
    .ex_memread     (ex_memread),
    .ex_rs          (ex_rs),
    .ex_rt          (ex_rt),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .hold           (hold),
    .mem_dst        (mem_dst),
    .mem_regwrite   (mem_regwrite),
    .mem_memread    (mem_memread),
    .wb_dst         (wb_dst),
    .wb_regwrite    (wb_regwrite),
    .fwd_a          (fwd_a),
    .fwd_b          (fwd_b),
    .load_use_stall (load_use_stall)
  );

  typedef struct {
    logic [3:0] dst;
    logic       v, rw, mr;
    logic [3:0] rs, rt, irs, irt;
    logic       hd;
    logic [3:0] e_mdst;
    logic       e_mrw, e_mmr;
    logic [3:0] e_wdst;
    logic       e_wrw;
    logic [1:0] e_fa, e_fb;
    logic       e_st;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] d, input logic v, input logic rw, input logic mr,
                       input logic [3:0] rs, input logic [3:0] rt,
                       input logic [3:0] irs, input logic [3:0] irt, input logic hd);
    ex_dst = d; ex_valid = v; ex_regwrite = rw; ex_memread = mr;
    ex_rs = rs; ex_rt = rt; id_rs = irs; id_rt = irt; hold = hd;
  endtask

  // Behavioural model state: what each stage holds after the last edge.
  logic [3:0] m_dst, w_dst;
  logic       m_we, m_ld, w_we;

  function automatic logic [1:0] model_fwd(input logic [3:0] src);
    if (m_we && m_dst == src) return 2'b10;
    if (w_we && w_dst == src) return 2'b01;
    return 2'b00;
  endfunction

  initial begin
    tbl[0] = '{4'd5,1'b1,1'b1,1'b0, 4'd0,4'd0,4'd0,4'd0,1'b0, 4'd0,1'b0,1'b0, 4'd0,1'b0, 2'b00,2'b00,1'b0};
    tbl[1] = '{4'd3,1'b1,1'b1,1'b0, 4'd5,4'd0,4'd0,4'd0,1'b0, 4'd5,1'b1,1'b0, 4'd0,1'b0, 2'b10,2'b00,1'b0};
    tbl[2] = '{4'd3,1'b1,1'b1,1'b0, 4'd5,4'd3,4'd0,4'd0,1'b0, 4'd3,1'b1,1'b0, 4'd5,1'b1, 2'b01,2'b10,1'b0};
    tbl[3] = '{4'd3,1'b1,1'b0,1'b0, 4'd3,4'd3,4'd0,4'd0,1'b0, 4'd3,1'b1,1'b0, 4'd3,1'b1, 2'b10,2'b10,1'b0};
    tbl[4] = '{4'd0,1'b1,1'b1,1'b0, 4'd3,4'd0,4'd0,4'd0,1'b0, 4'd3,1'b0,1'b0, 4'd3,1'b1, 2'b01,2'b00,1'b0};
    tbl[5] = '{4'd0,1'b1,1'b0,1'b1, 4'd0,4'd3,4'd0,4'd0,1'b0, 4'd0,1'b0,1'b0, 4'd3,1'b0, 2'b00,2'b00,1'b0};
    tbl[6] = '{4'd7,1'b1,1'b1,1'b1, 4'd0,4'd0,4'd1,4'd7,1'b0, 4'd0,1'b0,1'b1, 4'd0,1'b0, 2'b00,2'b00,1'b1};
    tbl[7] = '{4'd7,1'b0,1'b1,1'b1, 4'd7,4'd0,4'd0,4'd7,1'b0, 4'd7,1'b1,1'b1, 4'd0,1'b0, 2'b10,2'b00,1'b0};
    tbl[8] = '{4'd9,1'b1,1'b1,1'b0, 4'd7,4'd0,4'd0,4'd0,1'b0, 4'd7,1'b0,1'b0, 4'd7,1'b1, 2'b01,2'b00,1'b0};

    // Reset with a writing instruction presented.
    rst = 1'b1;
    drive(4'd5, 1'b1, 1'b1, 1'b0, 4'd0, 4'd5, 4'd0, 4'd0, 1'b0);
    #2;
    check("rst_mem_dst", mem_dst, 0);
    check("rst_wb_rw", wb_regwrite, 0);
    repeat (2) tick();
    check("rst_mem_dst_edge", mem_dst, 0);
    check("rst_mem_rw_edge", mem_regwrite, 0);
    check("rst_mem_mr_edge", mem_memread, 0);
    check("rst_wb_dst_edge", wb_dst, 0);
    check("rst_wb_rw_edge", wb_regwrite, 0);
    check("rst_fwd_a", fwd_a, 2'b00);
    check("rst_fwd_b", fwd_b, 2'b00);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].dst, tbl[i].v, tbl[i].rw, tbl[i].mr, tbl[i].rs, tbl[i].rt,
            tbl[i].irs, tbl[i].irt, tbl[i].hd);
      #2;
      check($sformatf("t%0d_mem_dst", i), mem_dst, tbl[i].e_mdst);
      check($sformatf("t%0d_mem_rw", i), mem_regwrite, tbl[i].e_mrw);
      check($sformatf("t%0d_mem_mr", i), mem_memread, tbl[i].e_mmr);
      check($sformatf("t%0d_wb_dst", i), wb_dst, tbl[i].e_wdst);
      check($sformatf("t%0d_wb_rw", i), wb_regwrite, tbl[i].e_wrw);
      check($sformatf("t%0d_fwd_a", i), fwd_a, tbl[i].e_fa);
      check($sformatf("t%0d_fwd_b", i), fwd_b, tbl[i].e_fb);
      check($sformatf("t%0d_stall", i), load_use_stall, tbl[i].e_st);
      tick();
    end

    // Hold: MEM has dst 9 (writing), WB has dst 7 (non-writing). Stall independent of hold.
    drive(4'd2, 1'b1, 1'b1, 1'b1, 4'd9, 4'd7, 4'd2, 4'd0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #2;
      check("hold_stall", load_use_stall, 1'b1);
      check("hold_fwd_a", fwd_a, 2'b10);
      check("hold_fwd_b", fwd_b, 2'b00);
      tick();
      check("hold_mem_dst", mem_dst, 4'd9);
      check("hold_mem_rw", mem_regwrite, 1'b1);
      check("hold_mem_mr", mem_memread, 1'b0);
      check("hold_wb_dst", wb_dst, 4'd7);
      check("hold_wb_rw", wb_regwrite, 1'b0);
    end
    drive(4'd4, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    tick();
    check("rel_wb_dst", wb_dst, 4'd9);
    check("rel_wb_rw", wb_regwrite, 1'b1);
    check("rel_mem_dst", mem_dst, 4'd4);
    drive(4'd6, 1'b1, 1'b1, 1'b0, 4'd6, 4'd4, 4'd0, 4'd0, 1'b0);
    tick();
    check("pre_arst_mem_rw", mem_regwrite, 1'b1);
    check("pre_arst_wb_rw", wb_regwrite, 1'b1);

    // Async reset between edges.
    #2;
    rst = 1'b1;
    #1;
    check("arst_wb_rw", wb_regwrite, 1'b0);
    check("arst_mem_rw", mem_regwrite, 1'b0);
    check("arst_wb_dst", wb_dst, 4'd0);
    check("arst_mem_dst", mem_dst, 4'd0);
    check("arst_fwd_a", fwd_a, 2'b00);
    check("arst_fwd_b", fwd_b, 2'b00);
    tick();
    rst = 1'b0;

    // Randomized run against the model.
    m_dst = '0; m_we = 1'b0; m_ld = 1'b0; w_dst = '0; w_we = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic [3:0] d, rs, rt, irs, irt;
      logic v, rw, mr, hd, e_we, e_ld, e_st;
      d   = 4'($urandom_range(7));
      rs  = 4'($urandom_range(7));
      rt  = 4'($urandom_range(7));
      irs = 4'($urandom_range(7));
      irt = 4'($urandom_range(7));
      v   = ($urandom_range(9) != 0);
      rw  = 1'($urandom);
      mr  = ($urandom_range(3) == 0);
      hd  = ($urandom_range(4) == 0);
      drive(d, v, rw, mr, rs, rt, irs, irt, hd);
      e_we = v && rw && (d != 0);
      e_ld = v && mr;
      e_st = e_ld && (d != 0) && (d == irs || d == irt);
      #2;
      check("rnd_mem_dst", mem_dst, m_dst);
      check("rnd_mem_rw", mem_regwrite, m_we);
      check("rnd_mem_mr", mem_memread, m_ld);
      check("rnd_wb_dst", wb_dst, w_dst);
      check("rnd_wb_rw", wb_regwrite, w_we);
      check("rnd_fwd_a", fwd_a, model_fwd(rs));
      check("rnd_fwd_b", fwd_b, model_fwd(rt));
      check("rnd_stall", load_use_stall, e_st);
      tick();
      if (!hd) begin
        w_dst = m_dst; w_we = m_we;
        m_dst = d; m_we = e_we; m_ld = e_ld;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
